// File: rtl/common.sv
`default_nettype none
// ============================================================================
//  Module   : common (package)
//  Purpose  : Shared types for the memory-stage data-bus request path:
//             access kinds, bus word, transfer size and the data-bus
//             request/response structures.
//  Revision : 1.0 - initial release
// ============================================================================
package common;

    typedef logic [31:0] word_t;

    // MEM_NONE and any value not listed below mean "no memory access".
    typedef enum logic [3:0] {
        MEM_NONE = 4'd0,
        MEM_LB   = 4'd1,
        MEM_LBU  = 4'd2,
        MEM_LH   = 4'd3,
        MEM_LHU  = 4'd4,
        MEM_LW   = 4'd5,
        MEM_SB   = 4'd6,
        MEM_SH   = 4'd7,
        MEM_SW   = 4'd8
    } mem_t;

    typedef enum logic [1:0] {
        MSIZE1 = 2'd0,
        MSIZE2 = 2'd1,
        MSIZE4 = 2'd2
    } msize_t;

    typedef struct packed {
        logic       valid;
        word_t      addr;
        msize_t     size;
        logic [3:0] strobe;
        word_t      data;
    } dbus_req_t;

    typedef struct packed {
        logic  addr_ok;
        logic  data_ok;
        word_t data;
    } dbus_resp_t;

endpackage : common
`default_nettype wire

// File: rtl/memreq_ctrl_encode.sv
`default_nettype none
// ============================================================================
//  Module   : memreq_encode
//  Purpose  : Combinational decode of one memory access into bus transfer
//             size, byte strobe and lane-replicated store data, plus
//             load/store classification and alignment check.
//  Ports    : mem_type   - access kind
//             addr_lo    - effective address bits [1:0]
//             wdata      - unaligned store source
//             size       - transfer size
//             strobe     - byte-lane write enables (0 for loads)
//             data       - replicated store data (0 for loads)
//             is_load    - access is a load
//             is_store   - access is a store
//             misaligned - halfword on odd address or word not on 4-byte
//  Revision : 1.0 - initial release
// ============================================================================
module memreq_encode
    import common::*;
(
    input  mem_t        mem_type,
    input  logic [1:0]  addr_lo,
    input  word_t       wdata,
    output msize_t      size,
    output logic [3:0]  strobe,
    output word_t       data,
    output logic        is_load,
    output logic        is_store,
    output logic        misaligned
);

    always_comb begin
        size       = MSIZE1;
        strobe     = 4'b0000;
        data       = '0;
        is_load    = 1'b0;
        is_store   = 1'b0;
        misaligned = 1'b0;
        case (mem_type)
            MEM_LB, MEM_LBU: begin
                is_load = 1'b1;
                size    = MSIZE1;
            end
            MEM_LH, MEM_LHU: begin
                is_load    = 1'b1;
                size       = MSIZE2;
                misaligned = addr_lo[0];
            end
            MEM_LW: begin
                is_load    = 1'b1;
                size       = MSIZE4;
                misaligned = |addr_lo;
            end
            MEM_SB: begin
                is_store = 1'b1;
                size     = MSIZE1;
                strobe   = 4'b0001 << addr_lo;
                data     = {4{wdata[7:0]}};
            end
            MEM_SH: begin
                is_store   = 1'b1;
                size       = MSIZE2;
                strobe     = 4'b0011 << addr_lo;
                data       = {2{wdata[15:0]}};
                misaligned = addr_lo[0];
            end
            MEM_SW: begin
                is_store   = 1'b1;
                size       = MSIZE4;
                strobe     = 4'b1111;
                data       = wdata;
                misaligned = |addr_lo;
            end
            default: ;
        endcase
    end

endmodule : memreq_encode
`default_nettype wire

// File: rtl/memreq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : memreq_ctrl
//  Purpose  : Memory-stage data-bus request controller. Checks alignment,
//             issues one load/store on the data bus, stalls the pipeline
//             until the response arrives and presents the raw read word
//             with its byte offset and access kind to the load extractor.
//  Ports    : clk, reset          - clock, synchronous active-high reset
//             op_valid            - memory-stage instruction present
//             mem_type/addr/wdata - access kind, effective address, store src
//             stall_in            - downstream cannot advance this cycle
//             flush               - squash current memory-stage instruction
//             dreq / dresp        - data-bus request / response
//             stall_out           - access pending, hold the pipeline
//             rdata_raw/rd_addr/rd_type - captured result of last access
//             exc_adel/exc_ades/badvaddr - misaligned load/store exception
//  Revision : 1.0 - initial release
// ============================================================================
module memreq_ctrl
    import common::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    input  mem_t        mem_type,
    input  word_t       addr,
    input  word_t       wdata,
    input  logic        stall_in,
    input  logic        flush,
    output dbus_req_t   dreq,
    input  dbus_resp_t  dresp,
    output logic        stall_out,
    output word_t       rdata_raw,
    output logic [1:0]  rd_addr,
    output mem_t        rd_type,
    output logic        exc_adel,
    output logic        exc_ades,
    output word_t       badvaddr
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_ADDR = 2'd1,
        S_WAIT_DATA = 2'd2,
        S_DONE      = 2'd3
    } state_t;

    state_t     state, state_next;
    logic       cancel, cancel_next;

    // Request held stable on the bus while waiting for addr_ok.
    word_t      lat_addr;
    msize_t     lat_size;
    logic [3:0] lat_strobe;
    word_t      lat_data;
    mem_t       lat_type;

    msize_t     enc_size;
    logic [3:0] enc_strobe;
    word_t      enc_data;
    logic       enc_load, enc_store, enc_misaligned;

    logic       issue;
    logic       latch_en;
    logic       capture;
    logic [1:0] cap_addr;
    mem_t       cap_type;

    memreq_encode u_encode (
        .mem_type   (mem_type),
        .addr_lo    (addr[1:0]),
        .wdata      (wdata),
        .size       (enc_size),
        .strobe     (enc_strobe),
        .data       (enc_data),
        .is_load    (enc_load),
        .is_store   (enc_store),
        .misaligned (enc_misaligned)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            cancel     <= 1'b0;
            lat_addr   <= '0;
            lat_size   <= MSIZE1;
            lat_strobe <= 4'b0000;
            lat_data   <= '0;
            lat_type   <= MEM_NONE;
            rdata_raw  <= '0;
            rd_addr    <= 2'b00;
            rd_type    <= MEM_NONE;
        end else begin
            state  <= state_next;
            cancel <= cancel_next;
            if (latch_en) begin
                lat_addr   <= addr;
                lat_size   <= enc_size;
                lat_strobe <= enc_strobe;
                lat_data   <= enc_data;
                lat_type   <= mem_type;
            end
            if (capture) begin
                rdata_raw <= dresp.data;
                rd_addr   <= cap_addr;
                rd_type   <= cap_type;
            end
        end
    end

    assign issue = op_valid & ~flush & (enc_load | enc_store) & ~enc_misaligned;

    always_comb begin
        state_next  = state;
        cancel_next = cancel;
        latch_en    = 1'b0;
        capture     = 1'b0;
        cap_addr    = lat_addr[1:0];
        cap_type    = lat_type;
        stall_out   = 1'b0;
        exc_adel    = 1'b0;
        exc_ades    = 1'b0;
        badvaddr    = '0;
        dreq.valid  = 1'b0;
        dreq.addr   = lat_addr;
        dreq.size   = lat_size;
        dreq.strobe = lat_strobe;
        dreq.data   = lat_data;

        case (state)
            S_IDLE: begin
                cancel_next = 1'b0;
                dreq.valid  = issue;
                dreq.addr   = addr;
                dreq.size   = enc_size;
                dreq.strobe = enc_strobe;
                dreq.data   = enc_data;
                cap_addr    = addr[1:0];
                cap_type    = mem_type;
                exc_adel    = op_valid & ~flush & enc_load  & enc_misaligned;
                exc_ades    = op_valid & ~flush & enc_store & enc_misaligned;
                if (exc_adel || exc_ades) begin
                    badvaddr = addr;
                end
                if (issue) begin
                    stall_out = 1'b1;
                    latch_en  = 1'b1;
                    if (dresp.addr_ok && dresp.data_ok) begin
                        capture    = 1'b1;
                        state_next = S_DONE;
                    end else if (dresp.addr_ok) begin
                        state_next = S_WAIT_DATA;
                    end else begin
                        state_next = S_WAIT_ADDR;
                    end
                end
            end

            S_WAIT_ADDR: begin
                // The request must stay up until accepted even if squashed;
                // a flush only marks the eventual response for discard.
                dreq.valid = 1'b1;
                stall_out  = 1'b1;
                if (flush) begin
                    cancel_next = 1'b1;
                end
                if (dresp.addr_ok) begin
                    if (dresp.data_ok) begin
                        if (cancel || flush) begin
                            cancel_next = 1'b0;
                            state_next  = S_IDLE;
                        end else begin
                            capture    = 1'b1;
                            state_next = S_DONE;
                        end
                    end else begin
                        state_next = S_WAIT_DATA;
                    end
                end
            end

            S_WAIT_DATA: begin
                stall_out = 1'b1;
                if (flush) begin
                    cancel_next = 1'b1;
                end
                if (dresp.data_ok) begin
                    if (cancel || flush) begin
                        cancel_next = 1'b0;
                        state_next  = S_IDLE;
                    end else begin
                        capture    = 1'b1;
                        state_next = S_DONE;
                    end
                end
            end

            S_DONE: begin
                if (!stall_in || flush) begin
                    state_next = S_IDLE;
                end
            end

            default: state_next = S_IDLE;
        endcase
    end

endmodule : memreq_ctrl
`default_nettype wire

// File: tb/tb_memreq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_memreq_ctrl
//  Purpose  : Directed self-checking bench for memreq_ctrl. Inputs change
//             1 ns after the rising edge; outputs are compared 1 ns later.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_memreq_ctrl;
    import common::*;

    logic       clk;
    logic       reset;
    logic       op_valid;
    mem_t       mem_type;
    word_t      addr;
    word_t      wdata;
    logic       stall_in;
    logic       flush;
    dbus_req_t  dreq;
    dbus_resp_t dresp;
    logic       stall_out;
    word_t      rdata_raw;
    logic [1:0] rd_addr;
    mem_t       rd_type;
    logic       exc_adel;
    logic       exc_ades;
    word_t      badvaddr;

    int n_checks = 0;
    int n_fail   = 0;
    int stall_cnt;

    memreq_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .op_valid  (op_valid),
        .mem_type  (mem_type),
        .addr      (addr),
        .wdata     (wdata),
        .stall_in  (stall_in),
        .flush     (flush),
        .dreq      (dreq),
        .dresp     (dresp),
        .stall_out (stall_out),
        .rdata_raw (rdata_raw),
        .rd_addr   (rd_addr),
        .rd_type   (rd_type),
        .exc_adel  (exc_adel),
        .exc_ades  (exc_ades),
        .badvaddr  (badvaddr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        op_valid = 1'b0;
        mem_type = MEM_NONE;
        addr     = '0;
        wdata    = '0;
        stall_in = 1'b0;
        flush    = 1'b0;
        dresp    = '0;
        tick();
        tick();
        reset = 1'b0;
        #1;

        // ---------------- reset state ----------------
        check("rst_valid",    32'(dreq.valid), 32'd0);
        check("rst_stall",    32'(stall_out),  32'd0);
        check("rst_adel",     32'(exc_adel),   32'd0);
        check("rst_ades",     32'(exc_ades),   32'd0);
        check("rst_badvaddr", badvaddr,        32'd0);
        check("rst_rdata",    rdata_raw,       32'd0);
        check("rst_rd_addr",  32'(rd_addr),    32'd0);
        check("rst_rd_type",  32'(rd_type),    32'd0);

        // ---------------- LW fast path ----------------
        tick();
        op_valid      = 1'b1;
        mem_type      = MEM_LW;
        addr          = 32'h0000_0100;
        dresp.addr_ok = 1'b1;
        dresp.data_ok = 1'b1;
        dresp.data    = 32'hDEAD_BEEF;
        #1;
        check("lw_issue_valid", 32'(dreq.valid), 32'd1);
        check("lw_issue_stall", 32'(stall_out),  32'd1);
        check("lw_issue_addr",  dreq.addr,       32'h0000_0100);
        check("lw_issue_size",  32'(dreq.size),  32'd2);
        check("lw_issue_strb",  32'(dreq.strobe), 32'd0);
        tick();
        dresp = '0;
        #1;
        check("lw_done_stall",   32'(stall_out),  32'd0);
        check("lw_done_valid",   32'(dreq.valid), 32'd0);
        check("lw_done_rdata",   rdata_raw,       32'hDEAD_BEEF);
        check("lw_done_rd_addr", 32'(rd_addr),    32'd0);
        check("lw_done_rd_type", 32'(rd_type),    32'(MEM_LW));
        tick();
        op_valid = 1'b0;

        // ---------------- SB encoding ----------------
        tick();
        op_valid = 1'b1;
        mem_type = MEM_SB;
        addr     = 32'h0000_0103;
        wdata    = 32'h1234_5678;
        #1;
        check("sb_valid",  32'(dreq.valid),  32'd1);
        check("sb_strobe", 32'(dreq.strobe), 32'b1000);
        check("sb_data",   dreq.data,        32'h7878_7878);
        check("sb_size",   32'(dreq.size),   32'd0);
        op_valid = 1'b0;

        // ---------------- SH encoding ----------------
        tick();
        op_valid = 1'b1;
        mem_type = MEM_SH;
        addr     = 32'h0000_0102;
        wdata    = 32'h0000_ABCD;
        #1;
        check("sh_strobe", 32'(dreq.strobe), 32'b1100);
        check("sh_data",   dreq.data,        32'hABCD_ABCD);
        check("sh_size",   32'(dreq.size),   32'd1);
        op_valid = 1'b0;

        // ---------------- misaligned accesses ----------------
        tick();
        op_valid = 1'b1;
        mem_type = MEM_LW;
        addr     = 32'h0000_0101;
        #1;
        check("mis_lw_adel",  32'(exc_adel),   32'd1);
        check("mis_lw_ades",  32'(exc_ades),   32'd0);
        check("mis_lw_bva",   badvaddr,        32'h0000_0101);
        check("mis_lw_valid", 32'(dreq.valid), 32'd0);
        check("mis_lw_stall", 32'(stall_out),  32'd0);
        mem_type = MEM_SH;
        addr     = 32'h0000_0201;
        #1;
        check("mis_sh_ades",  32'(exc_ades),   32'd1);
        check("mis_sh_adel",  32'(exc_adel),   32'd0);
        check("mis_sh_bva",   badvaddr,        32'h0000_0201);
        check("mis_sh_valid", 32'(dreq.valid), 32'd0);
        flush = 1'b1;
        #1;
        check("flush_mis_ades", 32'(exc_ades), 32'd0);
        mem_type = MEM_LW;
        addr     = 32'h0000_0104;
        #1;
        check("flush_idle_valid", 32'(dreq.valid), 32'd0);
        check("flush_idle_stall", 32'(stall_out),  32'd0);
        flush    = 1'b0;
        op_valid = 1'b0;

        // ---------------- delayed handshake LB ----------------
        tick();
        stall_cnt = 0;
        for (int cyc = 0; cyc < 9; cyc++) begin
            op_valid      = 1'b1;
            mem_type      = (cyc == 0) ? MEM_LB : MEM_SW;
            addr          = (cyc == 0) ? 32'h0000_01A2 : 32'hFFFF_FFFC;
            wdata         = 32'hCAFE_0000 + 32'(cyc);
            dresp.addr_ok = (cyc == 3);
            dresp.data_ok = (cyc == 5);
            dresp.data    = (cyc == 5) ? 32'h1122_3344 : 32'hBAD0_BAD0;
            stall_in      = (cyc == 6 || cyc == 7);
            #1;
            if (stall_out) stall_cnt++;
            if (cyc == 0) begin
                check("dly_issue_valid", 32'(dreq.valid), 32'd1);
            end
            if (cyc >= 1 && cyc <= 3) begin
                check($sformatf("dly_wa_valid_%0d", cyc),  32'(dreq.valid),  32'd1);
                check($sformatf("dly_wa_addr_%0d", cyc),   dreq.addr,        32'h0000_01A2);
                check($sformatf("dly_wa_strobe_%0d", cyc), 32'(dreq.strobe), 32'd0);
                check($sformatf("dly_wa_size_%0d", cyc),   32'(dreq.size),   32'd0);
            end
            if (cyc == 4) begin
                check("dly_wd_valid", 32'(dreq.valid), 32'd0);
            end
            if (cyc >= 6) begin
                check($sformatf("dly_done_stall_%0d", cyc), 32'(stall_out),  32'd0);
                check($sformatf("dly_done_valid_%0d", cyc), 32'(dreq.valid), 32'd0);
            end
            tick();
        end
        op_valid = 1'b0;
        stall_in = 1'b0;
        dresp    = '0;
        #1;
        check("dly_stall_cycles", 32'(stall_cnt),  32'd6);
        check("dly_rdata",        rdata_raw,       32'h1122_3344);
        check("dly_rd_addr",      32'(rd_addr),    32'd2);
        check("dly_rd_type",      32'(rd_type),    32'(MEM_LB));
        check("dly_idle_valid",   32'(dreq.valid), 32'd0);

        // ---------------- flush during WAIT_DATA ----------------
        tick();
        op_valid      = 1'b1;
        mem_type      = MEM_LHU;
        addr          = 32'h0000_0300;
        dresp.addr_ok = 1'b1;
        #1;
        tick();
        dresp = '0;
        flush = 1'b1;
        #1;
        check("fl_wd_stall1", 32'(stall_out), 32'd1);
        tick();
        flush = 1'b0;
        #1;
        check("fl_wd_stall2", 32'(stall_out), 32'd1);
        tick();
        dresp.data_ok = 1'b1;
        dresp.data    = 32'h0000_0055;
        #1;
        check("fl_drain_stall", 32'(stall_out), 32'd1);
        tick();
        dresp    = '0;
        op_valid = 1'b0;
        #1;
        check("fl_after_stall",   32'(stall_out), 32'd0);
        check("fl_after_rdata",   rdata_raw,      32'h1122_3344);
        check("fl_after_rd_type", 32'(rd_type),   32'(MEM_LB));
        // A fresh access must issue straight away from IDLE.
        op_valid      = 1'b1;
        mem_type      = MEM_LW;
        addr          = 32'h0000_0400;
        dresp.addr_ok = 1'b1;
        dresp.data_ok = 1'b1;
        dresp.data    = 32'hCAFE_F00D;
        #1;
        check("fl_next_valid", 32'(dreq.valid), 32'd1);
        tick();
        dresp = '0;
        #1;
        check("fl_next_rdata", rdata_raw,     32'hCAFE_F00D);
        check("fl_next_stall", 32'(stall_out), 32'd0);
        tick();
        op_valid = 1'b0;

        // ---------------- flush together with data_ok ----------------
        tick();
        op_valid      = 1'b1;
        mem_type      = MEM_LW;
        addr          = 32'h0000_0600;
        dresp.addr_ok = 1'b1;
        #1;
        tick();
        dresp.addr_ok = 1'b0;
        dresp.data_ok = 1'b1;
        dresp.data    = 32'h0000_0077;
        flush         = 1'b1;
        #1;
        check("fldo_stall", 32'(stall_out), 32'd1);
        tick();
        flush    = 1'b0;
        dresp    = '0;
        op_valid = 1'b0;
        #1;
        check("fldo_rdata", rdata_raw,      32'hCAFE_F00D);
        check("fldo_stall_after", 32'(stall_out), 32'd0);
        // Cancel must have cleared: next response is captured normally.
        op_valid      = 1'b1;
        mem_type      = MEM_LW;
        addr          = 32'h0000_0704;
        dresp.addr_ok = 1'b1;
        dresp.data_ok = 1'b1;
        dresp.data    = 32'h0000_0099;
        #1;
        tick();
        dresp = '0;
        #1;
        check("fldo_next_rdata", rdata_raw, 32'h0000_0099);
        tick();
        op_valid = 1'b0;

        // ---------------- reset during WAIT_ADDR ----------------
        tick();
        op_valid = 1'b1;
        mem_type = MEM_SW;
        addr     = 32'h0000_0500;
        wdata    = 32'hA5A5_A5A5;
        #1;
        check("sw_strobe", 32'(dreq.strobe), 32'hF);
        check("sw_data",   dreq.data,        32'hA5A5_A5A5);
        tick();
        op_valid = 1'b0;
        #1;
        check("rwa_valid", 32'(dreq.valid), 32'd1);
        check("rwa_stall", 32'(stall_out),  32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check("rwa_after_valid", 32'(dreq.valid), 32'd0);
        check("rwa_after_stall", 32'(stall_out),  32'd0);
        check("rwa_after_rdata", rdata_raw,       32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_memreq_ctrl
`default_nettype wire
